snake_head_ctrl: RTL and testbench
==================================

Name: snake_head_ctrl

Overview:
- Upstream of the per-cell trail-memory array. Owns snake head position, heading, length and game state.
- Each game tick it advances the head one cell and emits a one-cycle `step` strobe with `head_x/head_y`. The cell decoder turns that into the per-cell "head present" input.
- Each cell then holds itself lit for `len` ticks.
- Also detects food, body and wall collisions.

Parameters:
- GRID_W, 16, columns; head_x range 0..GRID_W-1
- GRID_H, 12, rows; head_y range 0..GRID_H-1
- TICK_DIV, 5_000_000, clk cycles per game tick (minimum 4)
- LEN_INIT, 3, length after start
- LEN_MAX, 226, length saturation; equals cell counter saturation value
- X0, 8, start column
- Y0, 6, start row

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a game from IDLE or DEAD
- dir_valid  in  1  qualifies dir
- dir  in  2  requested heading: 0 up, 1 right, 2 down, 3 left
- body_hit  in  1  occupancy of cell (probe_x, probe_y) from the cell array; combinational, valid same cycle
- food_x  in  $clog2(GRID_W)  food column
- food_y  in  $clog2(GRID_H)  food row
- probe_x  out  $clog2(GRID_W)  registered next-head column
- probe_y  out  $clog2(GRID_H)  registered next-head row
- head_x  out  $clog2(GRID_W)  current head column
- head_y  out  $clog2(GRID_H)  current head row
- step  out  1  one-cycle pulse on each head move
- len  out  8  current length, feeds cell array len
- food_eaten  out  1  one-cycle pulse, concurrent with step
- game_over  out  1  high in DEAD
- running  out  1  high in RUN

Behaviour:
- Reset values: state IDLE, head=(X0,Y0), heading=right, pending=right, len=LEN_INIT, tick_cnt=0, step=0, food_eaten=0, game_over=0, running=0. probe = (X0+1,Y0).
- Reset mid-game: same values next cycle. Any in-flight step is suppressed.
- FSM states:
  - IDLE: start goes to RUN. Head, heading and len are reloaded to reset values; tick_cnt=0.
  - RUN: tick_cnt counts 0..TICK_DIV-1 and wraps.
  - DEAD: holds everything and asserts game_over. start behaves as in IDLE.
- Direction:
  - In RUN, dir_valid latches dir into pending unless dir is the exact reverse of committed heading; reversals are ignored.
  - Last valid request before a commit wins.
  - Pending becomes heading only at commit.
- probe is re-registered every cycle from head + pending.
- Commit cycle is tick_cnt==TICK_DIV-1:
  - Collision check uses probe, which is stable since tick_cnt==TICK_DIV-2, and the same-cycle body_hit.
  - Wall case (feature off only): the move would leave the grid. Go to DEAD; no step.
  - body_hit=1: go to DEAD; no step, head unchanged. The tail cell counts as occupied; no tail exemption.
  - Otherwise: head<=probe, heading<=pending, step=1 for one cycle.
  - If probe==(food_x,food_y): food_eaten=1 and len<=len+1, saturating at LEN_MAX.
- Latency: step and the new head_x/head_y appear together, one cycle after commit. len increment is visible in the same cycle as that step.
- start in RUN is ignored. dir_valid outside RUN is ignored.
- Arithmetic: positions unsigned. Wrap math is done modulo GRID_W/GRID_H with explicit compare, not bit overflow.

Optional Feature:
- Macro: SNAKE_WRAP_EN.
- Defined: leaving an edge wraps to the opposite edge (x=GRID_W-1 moving right gives x=0; y=0 moving up gives y=GRID_H-1). Wall death never occurs.
- Undefined: edge exit goes to DEAD as above; probe holds the clamped current head.

Decomposition:
- Package snake_pkg: direction encoding (DIR_UP..DIR_LEFT), reverse-direction function, FSM state encoding, default grid constants, LEN_MAX.
- Sub-module game_tick_div: parameterised TICK_DIV counter with sync clear and enable. Outputs pre_tick (TICK_DIV-2) and tick (TICK_DIV-1).

Test Plan:
- TICK_DIV=4, reset, start, no dir input -> step every 4 cycles; head (9,6),(10,6),(11,6); len=3; running=1.
- Heading right; dir=left then dir=down in one tick -> left ignored, next step moves to y+1.
- Food at (9,6); start -> first step has food_eaten=1 and len=4; next step food_eaten=0.
- body_hit=1 forced at commit -> game_over=1 next cycle, no step, head unchanged; start -> RUN, head (8,6), len=3.
- Head at (15,6) heading right. Feature off -> DEAD. SNAKE_WRAP_EN on -> head (0,6) with step.
- len preloaded to 226 via 223 food hits -> further food_eaten pulses, len stays 226.
- reset asserted on the commit cycle -> no step; all outputs at reset values next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings and default constants for the snake head controller.
package snake_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam int GRID_W_DEF   = 16;
   localparam int GRID_H_DEF   = 12;
   localparam int TICK_DIV_DEF = 5_000_000;
   localparam int LEN_INIT_DEF = 3;
   localparam int LEN_MAX      = 226;
   localparam int X0_DEF       = 8;
   localparam int Y0_DEF       = 6;

   // Opposite headings differ only in bit 1 of the encoding.
   function automatic dir_t rev_dir(input dir_t d);
      return dir_t'(d ^ 2'd2);
   endfunction

endpackage

// File: rtl/game_tick_div.sv
// Game tick divider: counts 0..TICK_DIV-1 while enabled, flags the last two counts.
module game_tick_div #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic pre_tick,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] PRE  = CW'(TICK_DIV - 2);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr)
         cnt <= '0;
      else if (en)
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
   end

   assign pre_tick = en && (cnt == PRE);
   assign tick     = en && (cnt == LAST);

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: position, heading, length, game FSM and collisions.
// Define SNAKE_WRAP_EN to wrap at grid edges instead of dying on the wall.
module snake_head_ctrl
   import snake_pkg::*;
#(
   parameter int GRID_W   = GRID_W_DEF,
   parameter int GRID_H   = GRID_H_DEF,
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int LEN_INIT = LEN_INIT_DEF,
   parameter int LEN_MAX  = snake_pkg::LEN_MAX,
   parameter int X0       = X0_DEF,
   parameter int Y0       = Y0_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      dir_valid,
   input  logic [1:0]                dir,
   input  logic                      body_hit,
   input  logic [$clog2(GRID_W)-1:0] food_x,
   input  logic [$clog2(GRID_H)-1:0] food_y,
   output logic [$clog2(GRID_W)-1:0] probe_x,
   output logic [$clog2(GRID_H)-1:0] probe_y,
   output logic [$clog2(GRID_W)-1:0] head_x,
   output logic [$clog2(GRID_H)-1:0] head_y,
   output logic                      step,
   output logic [7:0]                len,
   output logic                      food_eaten,
   output logic                      game_over,
   output logic                      running
);

   localparam int XW = $clog2(GRID_W);
   localparam int YW = $clog2(GRID_H);
   localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
   localparam logic [XW-1:0] X_INIT   = XW'(X0);
   localparam logic [XW-1:0] X_PROBE0 = XW'(X0 + 1);
   localparam logic [YW-1:0] Y_INIT   = YW'(Y0);

   state_t          state, state_nxt;
   dir_t            heading, pending, probe_dir, ref_dir;
   logic [XW-1:0]   nxt_x;
   logic [YW-1:0]   nxt_y;
   logic            nxt_wall, probe_wall;
   logic            load, move, pre_tick, tick, dir_ok, food_hit;

   assign running   = (state == ST_RUN);
   assign game_over = (state == ST_DEAD);

   game_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk      (clk),
      .reset    (reset),
      .clr      (load),
      .en       (running),
      .pre_tick (pre_tick),
      .tick     (tick)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      move      = 1'b0;
      case (state)
         ST_RUN: begin
            if (tick) begin
               if (probe_wall || body_hit) state_nxt = ST_DEAD;
               else                        move      = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_nxt = ST_RUN;
               load      = 1'b1;
            end
         end
      endcase
   end

   // Candidate next head from head + pending; edge handling is the build option.
   always_comb begin
      nxt_x    = head_x;
      nxt_y    = head_y;
      nxt_wall = 1'b0;
      case (pending)
         DIR_UP: begin
            if (head_y == '0) begin
`ifdef SNAKE_WRAP_EN
               nxt_y = Y_MAX;
`else
               nxt_wall = 1'b1;
`endif
            end else nxt_y = head_y - 1'b1;
         end
         DIR_RIGHT: begin
            if (head_x == X_MAX) begin
`ifdef SNAKE_WRAP_EN
               nxt_x = '0;
`else
               nxt_wall = 1'b1;
`endif
            end else nxt_x = head_x + 1'b1;
         end
         DIR_DOWN: begin
            if (head_y == Y_MAX) begin
`ifdef SNAKE_WRAP_EN
               nxt_y = '0;
`else
               nxt_wall = 1'b1;
`endif
            end else nxt_y = head_y + 1'b1;
         end
         default: begin
            if (head_x == '0) begin
`ifdef SNAKE_WRAP_EN
               nxt_x = X_MAX;
`else
               nxt_wall = 1'b1;
`endif
            end else nxt_x = head_x - 1'b1;
         end
      endcase
   end

   // Requests arriving after the probe has frozen apply to the following move,
   // so they are checked against the direction that move will be made from.
   assign ref_dir  = tick ? probe_dir : (pre_tick ? pending : heading);
   assign dir_ok   = running && dir_valid && (dir_t'(dir) != rev_dir(ref_dir));
   assign food_hit = (probe_x == food_x) && (probe_y == food_y);

   always_ff @(posedge clk) begin
      if (reset) begin
         head_x     <= X_INIT;
         head_y     <= Y_INIT;
         heading    <= DIR_RIGHT;
         pending    <= DIR_RIGHT;
         len        <= 8'(LEN_INIT);
         step       <= 1'b0;
         food_eaten <= 1'b0;
         probe_x    <= X_PROBE0;
         probe_y    <= Y_INIT;
         probe_dir  <= DIR_RIGHT;
         probe_wall <= 1'b0;
      end else begin
         step       <= move;
         food_eaten <= move && food_hit;
         if (load) begin
            head_x     <= X_INIT;
            head_y     <= Y_INIT;
            heading    <= DIR_RIGHT;
            pending    <= DIR_RIGHT;
            len        <= 8'(LEN_INIT);
            probe_x    <= X_PROBE0;
            probe_y    <= Y_INIT;
            probe_dir  <= DIR_RIGHT;
            probe_wall <= 1'b0;
         end else begin
            probe_x    <= nxt_x;
            probe_y    <= nxt_y;
            probe_dir  <= pending;
            probe_wall <= nxt_wall;
            if (move) begin
               head_x  <= probe_x;
               head_y  <= probe_y;
               heading <= probe_dir;
               if (food_hit && (len < 8'(LEN_MAX))) len <= len + 8'd1;
            end
            if (dir_ok) pending <= dir_t'(dir);
         end
      end
   end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed self-checking bench for snake_head_ctrl with a 4-cycle game tick.
module tb_snake_head_ctrl;

   logic       clk = 1'b0;
   logic       reset, start, dir_valid, body_hit;
   logic [1:0] dir;
   logic [3:0] food_x, food_y, probe_x, probe_y, head_x, head_y;
   logic [7:0] len;
   logic       step, food_eaten, game_over, running;

   int n_chk = 0;
   int n_pass = 0;

   snake_head_ctrl #(.TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .start(start), .dir_valid(dir_valid), .dir(dir),
      .body_hit(body_hit), .food_x(food_x), .food_y(food_y),
      .probe_x(probe_x), .probe_y(probe_y), .head_x(head_x), .head_y(head_y),
      .step(step), .len(len), .food_eaten(food_eaten),
      .game_over(game_over), .running(running)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; dir_valid = 1'b0; dir = 2'd0; body_hit = 1'b0;
      food_x = 4'd0; food_y = 4'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_step(output bit ok, output int cyc);
      ok = 1'b0; cyc = 0;
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         if (step === 1'b1) begin ok = 1'b1; cyc = i; break; end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if (head_x !== 4'd8 || head_y !== 4'd6) $display("FAIL reset_head got (%0d,%0d) want (8,6)", head_x, head_y); else n_pass++;
      n_chk++; if (probe_x !== 4'd9 || probe_y !== 4'd6) $display("FAIL reset_probe got (%0d,%0d) want (9,6)", probe_x, probe_y); else n_pass++;
      n_chk++; if (len !== 8'd3) $display("FAIL reset_len got %0d want 3", len); else n_pass++;
      n_chk++; if ({step, food_eaten, game_over, running} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {step, food_eaten, game_over, running}); else n_pass++;
   endtask

   task automatic test_basic();
      bit ok; int cyc;
      do_reset();
      pulse_start();
      n_chk++; if (running !== 1'b1) $display("FAIL basic_running got %b want 1", running); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         wait_step(ok, cyc);
         n_chk++; if (!ok || cyc != 4) $display("FAIL basic_period%0d got ok=%0d cyc=%0d want ok=1 cyc=4", k, ok, cyc); else n_pass++;
         n_chk++; if (head_x !== 4'(9 + k) || head_y !== 4'd6) $display("FAIL basic_head%0d got (%0d,%0d) want (%0d,6)", k, head_x, head_y, 9 + k); else n_pass++;
      end
      n_chk++; if (len !== 8'd3) $display("FAIL basic_len got %0d want 3", len); else n_pass++;
   endtask

   task automatic test_turn();
      bit ok; int cyc;
      do_reset();
      pulse_start();
      dir_valid = 1'b1; dir = 2'd3;
      @(negedge clk);
      dir = 2'd2;
      @(negedge clk);
      dir_valid = 1'b0;
      wait_step(ok, cyc);
      n_chk++; if (!ok || head_x !== 4'd8 || head_y !== 4'd7) $display("FAIL turn_down got ok=%0d (%0d,%0d) want (8,7)", ok, head_x, head_y); else n_pass++;
      wait_step(ok, cyc);
      n_chk++; if (!ok || head_x !== 4'd8 || head_y !== 4'd8) $display("FAIL turn_keep got ok=%0d (%0d,%0d) want (8,8)", ok, head_x, head_y); else n_pass++;
   endtask

   task automatic test_food();
      bit ok; int cyc;
      do_reset();
      food_x = 4'd9; food_y = 4'd6;
      pulse_start();
      wait_step(ok, cyc);
      n_chk++; if (!ok || food_eaten !== 1'b1 || len !== 8'd4) $display("FAIL food_hit got ok=%0d eaten=%b len=%0d want 1,1,4", ok, food_eaten, len); else n_pass++;
      wait_step(ok, cyc);
      n_chk++; if (!ok || food_eaten !== 1'b0 || len !== 8'd4) $display("FAIL food_miss got ok=%0d eaten=%b len=%0d want 1,0,4", ok, food_eaten, len); else n_pass++;
   endtask

   task automatic test_body();
      bit ok; int cyc; bit saw;
      do_reset();
      pulse_start();
      body_hit = 1'b1;
      saw = 1'b0;
      repeat (3) begin @(negedge clk); if (step) saw = 1'b1; end
      n_chk++; if (game_over !== 1'b0) $display("FAIL body_early got game_over=%b want 0", game_over); else n_pass++;
      @(negedge clk);
      n_chk++; if (game_over !== 1'b1 || running !== 1'b0) $display("FAIL body_dead got game_over=%b running=%b want 1,0", game_over, running); else n_pass++;
      repeat (5) begin if (step) saw = 1'b1; @(negedge clk); end
      n_chk++; if (saw) $display("FAIL body_nostep got a step want none"); else n_pass++;
      n_chk++; if (head_x !== 4'd8 || head_y !== 4'd6 || game_over !== 1'b1) $display("FAIL body_hold got (%0d,%0d) go=%b want (8,6) go=1", head_x, head_y, game_over); else n_pass++;
      body_hit = 1'b0;
      pulse_start();
      n_chk++; if (running !== 1'b1 || game_over !== 1'b0 || len !== 8'd3 || head_x !== 4'd8 || head_y !== 4'd6)
         $display("FAIL body_restart got run=%b go=%b len=%0d (%0d,%0d) want 1,0,3 (8,6)", running, game_over, len, head_x, head_y); else n_pass++;
      wait_step(ok, cyc);
      n_chk++; if (!ok || head_x !== 4'd9 || head_y !== 4'd6) $display("FAIL body_move got ok=%0d (%0d,%0d) want (9,6)", ok, head_x, head_y); else n_pass++;
   endtask

   task automatic test_wall();
      bit ok; int cyc; bit saw;
      do_reset();
      pulse_start();
      for (int k = 0; k < 7; k++) wait_step(ok, cyc);
      n_chk++; if (!ok || head_x !== 4'd15 || head_y !== 4'd6) $display("FAIL wall_edge got ok=%0d (%0d,%0d) want (15,6)", ok, head_x, head_y); else n_pass++;
`ifdef SNAKE_WRAP_EN
      saw = 1'b0;
      wait_step(ok, cyc);
      n_chk++; if (!ok || head_x !== 4'd0 || head_y !== 4'd6 || game_over !== 1'b0) $display("FAIL wall_wrap got ok=%0d (%0d,%0d) go=%b want (0,6) go=0", ok, head_x, head_y, game_over); else n_pass++;
`else
      saw = 1'b0;
      repeat (6) begin @(negedge clk); if (step) saw = 1'b1; end
      n_chk++; if (saw || game_over !== 1'b1 || head_x !== 4'd15 || head_y !== 4'd6) $display("FAIL wall_dead got step=%0d go=%b (%0d,%0d) want 0,1 (15,6)", saw, game_over, head_x, head_y); else n_pass++;
`endif
   endtask

   task automatic test_saturate();
      bit ok; int cyc; int ex, ey, nx, ny, elen;
      do_reset();
      pulse_start();
      ex = 8; ey = 6;
      for (int k = 0; k < 225; k++) begin
         nx = ex; ny = ey;
         case (k % 4)
            0: nx = ex + 1;
            1: ny = ey + 1;
            2: nx = ex - 1;
            default: ny = ey - 1;
         endcase
         food_x = 4'(nx); food_y = 4'(ny);
         dir_valid = 1'b1; dir = 2'((k % 4 + 1) % 4);
         @(negedge clk);
         dir_valid = 1'b0;
         wait_step(ok, cyc);
         elen = (4 + k > 226) ? 226 : 4 + k;
         n_chk++; if (!ok || food_eaten !== 1'b1 || head_x !== 4'(nx) || head_y !== 4'(ny))
            $display("FAIL sat_eat%0d got ok=%0d eaten=%b (%0d,%0d) want 1,1 (%0d,%0d)", k, ok, food_eaten, head_x, head_y, nx, ny); else n_pass++;
         n_chk++; if (len !== 8'(elen)) $display("FAIL sat_len%0d got %0d want %0d", k, len, elen); else n_pass++;
         ex = nx; ey = ny;
      end
   endtask

   task automatic test_reset_commit();
      bit ok; int cyc;
      do_reset();
      food_x = 4'd9; food_y = 4'd6;
      pulse_start();
      wait_step(ok, cyc);
      n_chk++; if (!ok || len !== 8'd4) $display("FAIL rc_pre got ok=%0d len=%0d want 1,4", ok, len); else n_pass++;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_chk++; if (step !== 1'b0 || food_eaten !== 1'b0 || running !== 1'b0 || game_over !== 1'b0)
         $display("FAIL rc_flags got step=%b eaten=%b run=%b go=%b want 0000", step, food_eaten, running, game_over); else n_pass++;
      n_chk++; if (head_x !== 4'd8 || head_y !== 4'd6 || probe_x !== 4'd9 || probe_y !== 4'd6 || len !== 8'd3)
         $display("FAIL rc_state got head(%0d,%0d) probe(%0d,%0d) len=%0d want (8,6) (9,6) 3", head_x, head_y, probe_x, probe_y, len); else n_pass++;
      reset = 1'b0;
      @(negedge clk);
      n_chk++; if (step !== 1'b0 || head_x !== 4'd8) $display("FAIL rc_after got step=%b head_x=%0d want 0,8", step, head_x); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_turn();
      test_food();
      test_body();
      test_wall();
      test_saturate();
      test_reset_commit();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
